bcd_counter_2: RTL and testbench

//   Two-digit BCD up/down counter (00..99) with a built-in clock prescaler.

---
 rtl/bcd_counter_pkg.sv | 9 +
 rtl/bcd_digit.sv | 44 ++++
 rtl/bcd_counter_2.sv | 98 +++++++++
 tb/tb_bcd_counter_2.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// Shared types and digit limits for the two-digit BCD counter.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear/load/step with a combinational carry/borrow-out.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up_dn,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       co
);

    bcd_t q_d;

    assign co = en && (up_dn ? (q == BCD_MAX) : (q == BCD_MIN));

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = BCD_MIN;
        end else if (ld) begin
            // Out-of-range load nibbles clamp so the digit never holds a non-BCD value.
            q_d = (ld_val > BCD_MAX) ? BCD_MAX : ld_val;
        end else if (en) begin
            if (up_dn) begin
                q_d = (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q_d = (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BCD_MIN;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_counter_2.sv
// Two-digit BCD up/down counter with prescaler, run/stop toggle and tick/wrap pulses.
// Define BCD_SATURATE_EN to hold at 99/00 and stop instead of wrapping.
module bcd_counter_2
    import bcd_counter_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       up_dn,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          running_d, tick_d, wrap_d;
    logic          step, step_en;
    logic          ones_co, tens_co;

    // Step uses the pre-toggle running value, so start_stop never blocks a due step.
    assign step = running && (presc_q == PRESC_LAST) && !clear && !load;

`ifdef BCD_SATURATE_EN
    logic at_limit;
    assign at_limit = up_dn ? (out2 == BCD_MAX && out1 == BCD_MAX)
                            : (out2 == BCD_MIN && out1 == BCD_MIN);
    assign step_en  = step && !at_limit;
    assign wrap_d   = step && at_limit;
`else
    assign step_en  = step;
    assign wrap_d   = tens_co;
`endif

    always_comb begin
        presc_d   = presc_q;
        running_d = running ^ start_stop;
        tick_d    = step;
        if (clear || load || step) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = presc_q + 1'b1;
        end
`ifdef BCD_SATURATE_EN
        if (wrap_d) begin
            running_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            running <= running_d;
            tick    <= tick_d;
            wrap    <= wrap_d;
        end
    end

    bcd_digit u_ones (
        .clk    (clk),
        .rst    (rst),
        .en     (step_en),
        .up_dn  (up_dn),
        .clr    (clear),
        .ld     (load),
        .ld_val (load_val[3:0]),
        .q      (out1),
        .co     (ones_co)
    );

    bcd_digit u_tens (
        .clk    (clk),
        .rst    (rst),
        .en     (ones_co),
        .up_dn  (up_dn),
        .clr    (clear),
        .ld     (load),
        .ld_val (load_val[7:4]),
        .q      (out2),
        .co     (tens_co)
    );

endmodule

// File: tb/tb_bcd_counter_2.sv
// Bench for bcd_counter_2: directed literal checks plus random stimulus against a decimal model.
module tb_bcd_counter_2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       ss1 = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic       up_dn = 1'b1;
    logic [7:0] load_val = 8'h00;

    logic [3:0] a_out1, a_out2, b_out1, b_out2;
    logic       a_run, a_tick, a_wrap, b_run, b_tick, b_wrap;

    int checks = 0;
    int passes = 0;

    // Model state per instance: 0 = CLK_DIV 4, 1 = CLK_DIV 1.
    int m_val[2]  = '{0, 0};
    int m_pre[2]  = '{0, 0};
    bit m_run[2]  = '{0, 0};
    bit m_tick[2] = '{0, 0};
    bit m_wrap[2] = '{0, 0};

    bcd_counter_2 #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .up_dn      (up_dn),
        .out1       (a_out1),
        .out2       (a_out2),
        .running    (a_run),
        .tick       (a_tick),
        .wrap       (a_wrap)
    );

    bcd_counter_2 #(.CLK_DIV(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start_stop (ss1),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .up_dn      (up_dn),
        .out1       (b_out1),
        .out2       (b_out2),
        .running    (b_run),
        .tick       (b_tick),
        .wrap       (b_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int clamp9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        int  div;
        bit  ss, lim, st;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_val[i] = 0; m_pre[i] = 0; m_run[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                div = (i == 0) ? 4 : 1;
                ss  = (i == 0) ? start_stop : ss1;
                lim = up_dn ? (m_val[i] == 99) : (m_val[i] == 0);
                st  = m_run[i] && (m_pre[i] == div - 1) && !clear && !load;
                m_tick[i] = st;
                m_wrap[i] = st && lim;
                if (clear) begin
                    m_val[i] = 0; m_pre[i] = 0;
                end else if (load) begin
                    m_val[i] = clamp9(int'(load_val[7:4])) * 10 + clamp9(int'(load_val[3:0]));
                    m_pre[i] = 0;
                end else if (st) begin
                    m_pre[i] = 0;
                    if (!lim) m_val[i] = up_dn ? m_val[i] + 1 : m_val[i] - 1;
`ifndef BCD_SATURATE_EN
                    else m_val[i] = up_dn ? 0 : 99;
`endif
                end else if (m_run[i]) begin
                    m_pre[i] = m_pre[i] + 1;
                end
                m_run[i] = m_run[i] ^ ss;
`ifdef BCD_SATURATE_EN
                if (st && lim) m_run[i] = 1'b0;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_digits", int'({a_out2, a_out1}), to_bcd(m_val[0]));
            chk("a_running", int'(a_run), int'(m_run[0]));
            chk("a_tick", int'(a_tick), int'(m_tick[0]));
            chk("a_wrap", int'(a_wrap), int'(m_wrap[0]));
            chk("b_digits", int'({b_out2, b_out1}), to_bcd(m_val[1]));
            chk("b_running", int'(b_run), int'(m_run[1]));
            chk("b_tick", int'(b_tick), int'(m_tick[1]));
            chk("b_wrap", int'(b_wrap), int'(m_wrap[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ensure_run();
        if (!m_run[0]) begin
            start_stop = 1'b1;
            cyc(1);
            start_stop = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_digits", int'({a_out2, a_out1}), 0);
        chk("rst_flags", int'({a_run, a_tick, a_wrap}), 0);
        rst = 1'b0;

        // First step 4 cycles after start; CLK_DIV=1 instance steps every cycle
        start_stop = 1'b1; ss1 = 1'b1;
        cyc(1);
        start_stop = 1'b0; ss1 = 1'b0;
        chk("start_running", int'(a_run), 1);
        cyc(3);
        chk("no_early_tick", int'(a_tick), 0);
        cyc(1);
        chk("first_step", int'({a_out2, a_out1}), 8'h01);
        chk("first_tick", int'(a_tick), 1);
        chk("div1_steps", int'({b_out2, b_out1}), 8'h04);
        cyc(4);
        chk("second_step", int'({a_out2, a_out1}), 8'h02);

        // Up through 99
        load_val = 8'h98; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("load_tick_low", int'(a_tick), 0);
        cyc(4);
        chk("up_to_99", int'({a_out2, a_out1}), 8'h99);
        cyc(4);
        chk("up_wrap_flag", int'({a_tick, a_wrap}), 3);
`ifdef BCD_SATURATE_EN
        chk("up_sat_hold", int'({a_out2, a_out1}), 8'h99);
        chk("up_sat_stop", int'(a_run), 0);
`else
        chk("up_wrap_00", int'({a_out2, a_out1}), 8'h00);
`endif

        // Down with borrow, then 00 -> 99
        ensure_run();
        load_val = 8'h10; load = 1'b1; up_dn = 1'b0;
        cyc(1);
        load = 1'b0;
        cyc(4);
        chk("borrow_09", int'({a_out2, a_out1}), 8'h09);
        cyc(4);
        chk("down_08", int'({a_out2, a_out1}), 8'h08);
        load_val = 8'h00; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(4);
        chk("down_wrap_flag", int'(a_wrap), 1);
`ifdef BCD_SATURATE_EN
        chk("down_sat_hold", int'({a_out2, a_out1}), 8'h00);
`else
        chk("down_wrap_99", int'({a_out2, a_out1}), 8'h99);
`endif

        // Clamp and clear-over-load
        ensure_run();
        load_val = 8'hAF; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("clamp_99", int'({a_out2, a_out1}), 8'h99);
        clear = 1'b1; load = 1'b1; load_val = 8'h55; up_dn = 1'b1;
        cyc(1);
        clear = 1'b0; load = 1'b0;
        chk("clear_wins", int'({a_out2, a_out1}), 8'h00);

        // Stop at prescaler 2, idle, resume keeps phase
        cyc(1);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        chk("stopped", int'(a_run), 0);
        cyc(10);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        chk("resume_no_tick", int'(a_tick), 0);
        cyc(1);
        chk("resume_no_tick2", int'(a_tick), 0);
        cyc(1);
        chk("resume_step", int'({a_tick, a_out2, a_out1}), 9'h101);
        // start_stop coincident with a step edge
        cyc(3);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        chk("stop_on_step", int'({a_tick, a_run, a_out2, a_out1}), 10'h202);

        // Async reset between edges
        ensure_run();
        cyc(5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_a", int'({a_out2, a_out1, a_run, a_tick, a_wrap}), 0);
        chk("async_rst_b", int'({b_out2, b_out1, b_run, b_tick, b_wrap}), 0);
        cyc(1);
        rst = 1'b0;

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            clear      = ($urandom_range(0, 39) == 0);
            load       = ($urandom_range(0, 29) == 0);
            load_val   = 8'($urandom);
            start_stop = ($urandom_range(0, 19) == 0);
            ss1        = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            cyc(1);
        end
        clear = 1'b0; load = 1'b0; start_stop = 1'b0; ss1 = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
